mac_acc_collector: RTL and testbench

Consumer end of the mac_acc output stream. Samples the 22-bit accumulated neuron sum once per accumulation window, applies ReLU plus a shift-and-saturate quantiser, and tracks the arg-max across NUM_NEURONS neurons. It presents the winning class and score on a valid/ready result port. This is the hardware replacement for the bench-side dout capture and file dump.

---
 rtl/mac_acc_pkg.sv | 19 +
 rtl/mac_acc_collector_relu_quant.sv | 33 +++
 rtl/mac_acc_collector.sv | 153 +++++++++++++++
 tb/tb_mac_acc_collector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pkg.sv
// Shared constants and types for the mac_acc result collector.
// Defaults match the mac_acc output stream (22-bit signed accumulator).
package mac_acc_pkg;

  localparam int DIN_W       = 22;
  localparam int OUT_W       = 8;
  localparam int SHIFT       = 6;
  localparam int ACC_BEATS   = 4;
  localparam int NUM_NEURONS = 10;

  localparam int CLS_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int BEAT_W = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

endpackage

// File: rtl/mac_acc_collector_relu_quant.sv
// relu_quant: combinational ReLU + shift-and-saturate quantiser.
// Ports: din (signed IN_W) -> q (unsigned Q_W); negative -> 0.
module relu_quant
  import mac_acc_pkg::*;
#(
  parameter int IN_W = DIN_W,
  parameter int SH   = SHIFT,
  parameter int Q_W  = OUT_W
) (
  input  logic [IN_W-1:0] din,
  output logic [Q_W-1:0]  q
);

  logic [IN_W-1:0] w_t;
  logic            w_sat;

  // Only reached for non-negative din, so a logical shift
  // gives the same result as an arithmetic one.
  assign w_t   = din >> SH;
  assign w_sat = |w_t[IN_W-1:Q_W];

  always_comb begin
    q = '0;
    if (din[IN_W-1]) begin
      q = '0;
    end else if (w_sat) begin
      q = '1;
    end else begin
      q = w_t[Q_W-1:0];
    end
  end

endmodule

// File: rtl/mac_acc_collector.sv
// mac_acc_collector: samples one mac_acc sum per ACC_BEATS-beat window,
// quantises it, tracks the arg-max over NUM_NEURONS and offers the winner
// on a valid/ready result port.
// Ports: clk, rst (sync, active-low), in_valid, din, res_valid, res_ready,
//        res_class, res_score, overrun (sticky).
// Option MAC_COLLECT_DBG_EN: per-neuron score file, dbg_idx/dbg_score.
module mac_acc_collector
  import mac_acc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DIN_W-1:0] din,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CLS_W-1:0] res_class,
  output logic [OUT_W-1:0] res_score,
  output logic             overrun
`ifdef MAC_COLLECT_DBG_EN
  ,
  input  logic [CLS_W-1:0] dbg_idx,
  output logic [OUT_W-1:0] dbg_score
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [BEAT_W-1:0] r_beat;
  logic [CLS_W-1:0]  r_neu;
  logic [OUT_W-1:0]  r_best;
  logic [CLS_W-1:0]  r_best_idx;
  logic [CLS_W-1:0]  r_res_class;
  logic [OUT_W-1:0]  r_res_score;
  logic              r_overrun;

  logic [OUT_W-1:0]  w_q;
  logic              w_beat_last;
  logic              w_neu_last;
  logic              w_cap;
  logic              w_take;
  logic [OUT_W-1:0]  w_best_nx;
  logic [CLS_W-1:0]  w_idx_nx;

  relu_quant #(
    .IN_W (DIN_W),
    .SH   (SHIFT),
    .Q_W  (OUT_W)
  ) u_quant (
    .din (din),
    .q   (w_q)
  );

  assign w_beat_last = (r_beat == BEAT_W'(ACC_BEATS - 1));
  assign w_neu_last  = (r_neu == CLS_W'(NUM_NEURONS - 1));
  assign w_cap       = (r_state == COLLECT) && in_valid && w_beat_last;

  // Strict compare keeps the lower index on ties; the first neuron
  // of a frame always seeds the running max.
  assign w_take    = (r_neu == '0) || (w_q > r_best);
  assign w_best_nx = w_take ? w_q : r_best;
  assign w_idx_nx  = w_take ? r_neu : r_best_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT: begin
        if (w_cap && w_neu_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          w_next = COLLECT;
        end
      end
      default: w_next = COLLECT;
    endcase
  end

  always_comb begin
    res_valid = (r_state == DONE);
    res_class = r_res_class;
    res_score = r_res_score;
    overrun   = r_overrun;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_beat      <= '0;
      r_neu       <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_res_class <= '0;
      r_res_score <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if ((r_state == COLLECT) && in_valid) begin
        r_beat <= w_beat_last ? '0 : r_beat + BEAT_W'(1);
      end
      if (w_cap) begin
        r_neu      <= w_neu_last ? '0 : r_neu + CLS_W'(1);
        r_best     <= w_best_nx;
        r_best_idx <= w_idx_nx;
        // Result registers load only on the final capture so they stay
        // frozen while the next frame accumulates.
        if (w_neu_last) begin
          r_res_class <= w_idx_nx;
          r_res_score <= w_best_nx;
        end
      end
      if ((r_state == DONE) && in_valid) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef MAC_COLLECT_DBG_EN
  logic [OUT_W-1:0] r_dbg [NUM_NEURONS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_dbg[i] <= '0;
      end
    end else if (w_cap) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (r_neu == CLS_W'(i)) begin
          r_dbg[i] <= w_q;
        end
      end
    end
  end

  // Decoded readback so out-of-range indices fall through to zero.
  always_comb begin
    dbg_score = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (dbg_idx == CLS_W'(i)) begin
        dbg_score = r_dbg[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_acc_collector.sv
// Directed self-checking bench for mac_acc_collector.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mac_acc_collector;
  import mac_acc_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [DIN_W-1:0] din = '0;
  logic             res_ready = 1'b0;
  logic             res_valid;
  logic [CLS_W-1:0] res_class;
  logic [OUT_W-1:0] res_score;
  logic             overrun;
`ifdef MAC_COLLECT_DBG_EN
  logic [CLS_W-1:0] dbg_idx = '0;
  logic [OUT_W-1:0] dbg_score;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [DIN_W-1:0] fr [NUM_NEURONS];

  localparam logic [DIN_W-1:0] JUNK = 22'h1FFFFF;

  mac_acc_collector dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din       (din),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
    .res_score (res_score),
    .overrun   (overrun)
`ifdef MAC_COLLECT_DBG_EN
    ,
    .dbg_idx   (dbg_idx),
    .dbg_score (dbg_score)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [DIN_W-1:0] v);
    for (int i = 0; i < NUM_NEURONS; i++) fr[i] = v;
  endtask

  // Non-capture beats carry JUNK so a misaligned capture shows up
  // as a saturated score.
  task automatic send_frame(input bit gaps);
    for (int n = 0; n < NUM_NEURONS; n++) begin
      for (int b = 0; b < ACC_BEATS; b++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            in_valid = 1'b0;
            din      = JUNK;
          end
        end
        @(negedge clk);
        if (n == NUM_NEURONS - 1 && b == ACC_BEATS - 1)
          chk("early_valid", 32'(res_valid), 32'd0);
        in_valid = 1'b1;
        din      = (b == ACC_BEATS - 1) ? fr[n] : JUNK;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    din      = '0;
  endtask

  task automatic check_res(input string tag,
                           input logic [31:0] cls,
                           input logic [31:0] scr);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_class"}, 32'(res_class), cls);
    chk({tag, "_score"}, 32'(res_score), scr);
  endtask

  task automatic accept();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("accept_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    // Reset held with a live beat on the input.
    rst      = 1'b0;
    in_valid = 1'b1;
    din      = 22'h000100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_class", 32'(res_class), 32'd0);
    chk("rst_score", 32'(res_score), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    din      = '0;
    @(negedge clk);

    // Nominal: neuron 3 -> 0xC80 >> 6 = 50.
    fill(22'h000040);
    fr[3] = 22'h000C80;
    send_frame(1'b0);
    check_res("nom", 32'd3, 32'h32);
    chk("nom_overrun", 32'(overrun), 32'd0);

    // Backpressure: three dropped beats set overrun, result frozen.
    res_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      din      = JUNK;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_overrun", 32'(overrun), 32'd1);
    check_res("bp", 32'd3, 32'h32);
    accept();

    // All negative: every q is 0, index 0 wins.
    fill(22'h3FFFFF);
    send_frame(1'b0);
    check_res("neg", 32'd0, 32'h00);
    chk("neg_overrun", 32'(overrun), 32'd1);
    accept();

    // Tie between neurons 2 and 7: lower index kept.
    fill(22'h000000);
    fr[2] = 22'h000400;
    fr[7] = 22'h000400;
    send_frame(1'b0);
    check_res("tie", 32'd2, 32'h10);
    accept();

    // Saturation on the last neuron, random idle gaps.
    fill(22'h000C80);
    fr[9] = 22'h1FFFFF;
    send_frame(1'b1);
    check_res("sat", 32'd9, 32'hFF);
    accept();

    // Mid-frame reset after 17 beats of large values.
    repeat (17) begin
      @(negedge clk);
      in_valid = 1'b1;
      din      = JUNK;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    chk("mrst_valid", 32'(res_valid), 32'd0);
    chk("mrst_overrun", 32'(overrun), 32'd0);
    fill(22'h000000);
    fr[5] = 22'h001000;
    send_frame(1'b0);
    check_res("mrst", 32'd5, 32'h40);

`ifdef MAC_COLLECT_DBG_EN
    dbg_idx = CLS_W'(5);
    #1 chk("dbg_5", 32'(dbg_score), 32'h40);
    dbg_idx = CLS_W'(0);
    #1 chk("dbg_0", 32'(dbg_score), 32'h00);
    dbg_idx = CLS_W'(12);
    #1 chk("dbg_oob", 32'(dbg_score), 32'h00);
`endif

    accept();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
